error_cmd_pulser: RTL and testbench
===================================

// Module: error_cmd_pulser
// PURPOSE
//  AGC-side driver of the CDU error-angle counter interface. Accepts a signed
//  ones-complement drive command and emits it as a train of active-low
//  _pPCH/_mPCH pulses, one per pulse-rate slot. The CDU error-angle counter
//  consumes these pulses. Gated by the error-counter enable, with abort on loss
//  of enable.
// PARAMETERS
//  PULSE_W     4    clocks each _pPCH/_mPCH pulse is held low (>=1)
//  MAX_PULSES  384  magnitude saturation limit per command
//  CMD_W       15   command width; MSB = sign, ones-complement
// PORTS
//  clk          in   1      system clock, all logic on rising edge
//  rst          in   1      synchronous reset, active-high
//  slot_tick    in   1      1-clk strobe, pulse-rate slot (3200 pps derived)
//  eec_en       in   1      error-counter enable, active-high
//  cmd_valid    in   1      command offered
//  cmd_data     in   CMD_W  signed ones-complement pulse count
//  cmd_ready    out  1      block can accept a command
//  _pPCH        out  1      plus drive pulse, active-low
//  _mPCH        out  1      minus drive pulse, active-low
//  busy         out  1      command in progress
//  remaining    out  9      pulses still to send
//  done         out  1      1-clk strobe: command fully sent
//  aborted      out  1      1-clk strobe: command dropped on loss of eec_en
// BEHAVIOUR
//  - Reset (any cycle, incl. mid-pulse): state IDLE, _pPCH=_mPCH=1,
//    cmd_ready=1 if eec_en else 0, busy=0, remaining=0, done=aborted=0.
//  - cmd_ready = (state==IDLE) & eec_en. Accept on cmd_valid&cmd_ready.
//    cmd_data is sampled only on acceptance.
//  - LOAD (1 clk): dir = cmd_data[CMD_W-1].
//    mag = dir ? ~cmd_data[CMD_W-2:0] : cmd_data[CMD_W-2:0].
//    remaining = min(mag, MAX_PULSES). A magnitude of +0 or -0 ends the command:
//    done fires in the LOAD cycle and the block returns to IDLE.
//    A slot_tick in the LOAD cycle is ignored.
//  - WAIT: on slot_tick, go to PULSE and drive the selected line low:
//    _pPCH for positive, _mPCH for negative. Never both.
//  - PULSE: the line is held low for exactly PULSE_W clks. remaining
//    decrements in the first PULSE clk. Ticks during PULSE are dropped, not
//    queued. At the end of PULSE, go to WAIT if remaining!=0. Otherwise pulse
//    done for 1 clk and go to IDLE.
//  - Latency: the first pulse falls 1 clk after the first slot_tick seen in
//    WAIT. Back-to-back pulses are spaced by slot ticks, never closer than
//    PULSE_W+1.
//  - eec_en low in LOAD/WAIT/PULSE: next clk goes to IDLE, the line is released
//    high, remaining=0 and aborted pulses for 1 clk. A partial PULSE is
//    allowed to truncate.
//  - eec_en low in IDLE: cmd_ready=0, no strobe.
//  - cmd_valid while busy: ignored (ready=0). There is no command queue.
//  - Outputs are registered; no combinational path from inputs to
//    _pPCH/_mPCH.
// STRUCTURE
//  - cdu_pkg: state enum {IDLE,LOAD,WAIT,PULSE}, oc_magnitude()
//    ones-complement helper, CDU_CNT_W=9.
//  - Sub-module pulse_stretcher: PULSE_W-wide counter, start in, low-true
//    out, and a clear input used for abort and reset.
// TESTING
//  - cmd=+5 (0x0005), ticks every 20 clk -> 5 _pPCH pulses each 4 clk
//    low, _mPCH idle, done once, remaining 5->0.
//  - cmd=-3 (0x7FFC) -> 3 _mPCH pulses, _pPCH stays 1, done once.
//  - cmd=+0 (0x0000) and -0 (0x7FFF) -> no pulses, done in the LOAD cycle,
//    cmd_ready back high the next clk.
//  - cmd=+1000 -> remaining loads 384; 384 pulses then done.
//  - cmd=+10; drop eec_en in the 3rd PULSE clk of pulse 4 -> line high next
//    clk, aborted=1 for 1 clk, remaining=0, no done.
//  - tick every 2 clk with PULSE_W=4; rst mid-PULSE -> extra ticks dropped,
//    spacing >=5; reset releases the line and clears state next clk.

Source files
------------

// File: rtl/cdu_pkg.sv
// Shared types and helpers for the CDU error-angle drive path.
// Holds the command FSM state encoding and ones-complement magnitude extraction.
package cdu_pkg;

  localparam int CDU_CNT_W = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WAIT  = 2'd2,
    PULSE = 2'd3
  } state_t;

  // Magnitude of a ones-complement value whose sign was split off; only the low
  // w bits are meaningful, the rest are returned as zero.
  function automatic logic [30:0] oc_magnitude(input logic sign,
                                               input logic [30:0] bits,
                                               input int w);
    logic [30:0] res;
    res = '0;
    for (int i = 0; i < 31; i++) begin
      if (i < w) res[i] = bits[i] ^ sign;
    end
    return res;
  endfunction

endpackage

// File: rtl/pulse_stretcher.sv
// Holds a low-true line for PULSE_W clocks after a start strobe.
// clear releases the line at once and doubles as the synchronous reset.
module pulse_stretcher #(
  parameter int PULSE_W = 4
) (
  input  logic clk,
  input  logic clear,
  input  logic start,
  output logic line_n,
  output logic last
);

  localparam int CW = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (clear) begin
      line_n <= 1'b1;
      cnt    <= '0;
    end else if (start) begin
      line_n <= 1'b0;
      cnt    <= CW'(PULSE_W - 1);
    end else if (!line_n) begin
      if (cnt == '0) line_n <= 1'b1;
      else           cnt    <= cnt - CW'(1);
    end
  end

  // High during the final low clock, so the owner can leave PULSE on time.
  assign last = ~line_n & (cnt == '0);

endmodule

// File: rtl/error_cmd_pulser.sv
// Turns a signed ones-complement drive command into a train of active-low
// _pPCH/_mPCH pulses, one per pulse-rate slot, gated by the error-counter enable.
module error_cmd_pulser
  import cdu_pkg::*;
#(
  parameter int PULSE_W    = 4,
  parameter int MAX_PULSES = 384,
  parameter int CMD_W      = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 slot_tick,
  input  logic                 eec_en,
  input  logic                 cmd_valid,
  input  logic [CMD_W-1:0]     cmd_data,
  output logic                 cmd_ready,
  output logic                 _pPCH,
  output logic                 _mPCH,
  output logic                 busy,
  output logic [CDU_CNT_W-1:0] remaining,
  output logic                 done,
  output logic                 aborted,
  output state_t               state_dbg
);

  // Handshake: a command transfers on the rising edge where cmd_valid and
  // cmd_ready are both high; cmd_data is only looked at on that edge.
  state_t               state_q, state_d;
  logic [CMD_W-1:0]     cmd_q;
  logic [CDU_CNT_W-1:0] rem_q, rem_d;
  logic                 done_q, done_d, aborted_q, aborted_d;
  logic                 accept, start, abort, clear;
  logic                 start_p, start_m, last_p, last_m;
  logic [30:0]          mag_in, mag_q;
  logic [CDU_CNT_W-1:0] sat_q;

  assign accept = cmd_valid & cmd_ready;
  assign mag_in = oc_magnitude(cmd_data[CMD_W-1], 31'(cmd_data[CMD_W-2:0]), CMD_W - 1);
  assign mag_q  = oc_magnitude(cmd_q[CMD_W-1], 31'(cmd_q[CMD_W-2:0]), CMD_W - 1);
  assign sat_q  = (mag_q > 31'(MAX_PULSES)) ? CDU_CNT_W'(MAX_PULSES)
                                            : mag_q[CDU_CNT_W-1:0];

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = LOAD;
          // A zero command finishes in its LOAD cycle, so done is armed here.
          done_d  = (mag_in == '0);
        end
      end
      LOAD: begin
        if (mag_q == '0)  state_d = IDLE;
        else if (!eec_en) abort   = 1'b1;
        else begin
          state_d = WAIT;
          rem_d   = sat_q;
        end
      end
      WAIT: begin
        if (!eec_en) abort = 1'b1;
        else if (slot_tick) begin
          state_d = PULSE;
          start   = 1'b1;
          rem_d   = rem_q - CDU_CNT_W'(1);
        end
      end
      PULSE: begin
        if (!eec_en) abort = 1'b1;
        else if (last_p | last_m) begin
          if (rem_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d   = IDLE;
      rem_d     = '0;
      aborted_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cmd_q     <= '0;
      rem_q     <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      if (accept) cmd_q <= cmd_data;
    end
  end

  // One stretcher per line keeps each output straight from a flop.
  assign clear   = rst | abort;
  assign start_p = start & ~cmd_q[CMD_W-1];
  assign start_m = start &  cmd_q[CMD_W-1];

  pulse_stretcher #(.PULSE_W(PULSE_W)) u_plus (
    .clk    (clk),
    .clear  (clear),
    .start  (start_p),
    .line_n (_pPCH),
    .last   (last_p)
  );

  pulse_stretcher #(.PULSE_W(PULSE_W)) u_minus (
    .clk    (clk),
    .clear  (clear),
    .start  (start_m),
    .line_n (_mPCH),
    .last   (last_m)
  );

  assign cmd_ready = (state_q == IDLE) & eec_en;
  assign busy      = (state_q != IDLE);
  assign remaining = rem_q;
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_error_cmd_pulser.sv
// Randomized and directed bench for error_cmd_pulser: pulse counts, widths,
// spacing and strobes are checked against a transaction-level expectation.
module tb_error_cmd_pulser;

  localparam int PULSE_W    = 4;
  localparam int MAX_PULSES = 384;
  localparam int CMD_W      = 15;

  logic              clk = 1'b0;
  logic              rst, slot_tick, eec_en, cmd_valid;
  logic [CMD_W-1:0]  cmd_data;
  logic              cmd_ready, p_pch, m_pch, busy, done, aborted;
  logic [8:0]        remaining;
  cdu_pkg::state_t   state_dbg;

  error_cmd_pulser #(.PULSE_W(PULSE_W), .MAX_PULSES(MAX_PULSES), .CMD_W(CMD_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .slot_tick (slot_tick),
    .eec_en    (eec_en),
    .cmd_valid (cmd_valid),
    .cmd_data  (cmd_data),
    .cmd_ready (cmd_ready),
    ._pPCH     (p_pch),
    ._mPCH     (m_pch),
    .busy      (busy),
    .remaining (remaining),
    .done      (done),
    .aborted   (aborted),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [8:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- slot tick source ----------------
  int tick_period = 0;
  int tick_cnt    = 0;
  initial begin
    slot_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (tick_period > 0) begin
        tick_cnt++;
        slot_tick = (tick_cnt >= tick_period);
        if (slot_tick) tick_cnt = 0;
      end else begin
        slot_tick = 1'b0;
      end
    end
  end

  // ---------------- line monitor ----------------
  int   cyc = 0, p_cnt = 0, m_cnt = 0, done_cnt = 0, ab_cnt = 0;
  int   last_fall = -1, fall_p = 0, fall_m = 0, exp_rem = 0;
  logic prev_p = 1'b1, prev_m = 1'b1, tick_prev = 1'b0;
  bit   trunc_ok = 1'b0;

  task automatic on_fall();
    check_eq("tick_latency", tick_prev, 1);
    if (last_fall >= 0) check_eq("spacing_ok", (cyc - last_fall) >= (PULSE_W + 1), 1);
    exp_rem--;
    check_eq("remaining_dec", remaining, exp_rem);
    last_fall = cyc;
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!p_pch && !m_pch) check_eq("never_both_low", 0, 1);
    if (prev_p && !p_pch) begin p_cnt++; fall_p = cyc; on_fall(); end
    if (prev_m && !m_pch) begin m_cnt++; fall_m = cyc; on_fall(); end
    if (!prev_p && p_pch && !trunc_ok) check_eq("p_width", cyc - fall_p, PULSE_W);
    if (!prev_m && m_pch && !trunc_ok) check_eq("m_width", cyc - fall_m, PULSE_W);
    if (done) done_cnt++;
    if (aborted) ab_cnt++;
    if (done && aborted) check_eq("done_and_aborted", 1, 0);
    prev_p    = p_pch;
    prev_m    = m_pch;
    tick_prev = slot_tick;
  end

  // ---------------- driver tasks ----------------
  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    p_cnt = 0; m_cnt = 0; done_cnt = 0; ab_cnt = 0; last_fall = -1;
  endtask

  task automatic send_cmd(input logic [CMD_W-1:0] c, output int sat);
    int mag;
    bit got;
    mag = c[CMD_W-1] ? (16383 - int'(c[13:0])) : int'(c[13:0]);
    sat = (mag > MAX_PULSES) ? MAX_PULSES : mag;
    exp_q.push_back(9'(sat));
    exp_rem = sat;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_data  = c;
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      sample();
      if (cmd_ready) begin got = 1'b1; break; end
    end
    if (!got) check_eq("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_data  = CMD_W'($urandom);
    sample();
    check_eq("load_done", done, sat == 0);
    check_eq("load_busy", busy, 1);
    check_eq("load_ready", cmd_ready, 0);
    sample();
    if (sat == 0) begin
      check_eq("zero_ready_back", cmd_ready, 1);
      check_eq("zero_remaining", remaining, 0);
      check_eq("zero_done_clear", done, 0);
    end else begin
      check_eq("remaining_load", remaining, sat);
    end
  endtask

  task automatic finish_cmd(input logic dir, input int period);
    logic [8:0] exp;
    int budget;
    exp = exp_q.pop_front();
    budget = (int'(exp) + 2) * (period + PULSE_W + 2) + 20;
    for (int i = 0; i < budget && done_cnt == 0 && ab_cnt == 0; i++) sample();
    if (done_cnt == 0 && ab_cnt == 0) check_eq("done_timeout", 0, 1);
    check_eq(dir ? "m_count" : "p_count", dir ? m_cnt : p_cnt, exp);
    check_eq(dir ? "p_idle" : "m_idle", dir ? p_cnt : m_cnt, 0);
    check_eq("end_busy", busy, 0);
    check_eq("end_remaining", remaining, 0);
    sample();
    check_eq("done_once", done_cnt, 1);
    check_eq("no_abort", ab_cnt, 0);
    check_eq("ready_idle", cmd_ready, 1);
  endtask

  task automatic run_cmd(input logic [CMD_W-1:0] c, input int period);
    int sat;
    tick_period = period;
    clear_mon();
    send_cmd(c, sat);
    finish_cmd(c[CMD_W-1], period);
  endtask

  task automatic wait_p(input int n);
    for (int i = 0; i < 400 && p_cnt < n; i++) sample();
    if (p_cnt < n) check_eq("pulse_wait_timeout", p_cnt, n);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int sat;
    logic [CMD_W-1:0] c;
    int mag, period;
    bit big;
    rst = 1'b1; eec_en = 1'b1; cmd_valid = 1'b0; cmd_data = '0;
    repeat (2) sample();
    check_eq("rst_p", p_pch, 1);
    check_eq("rst_m", m_pch, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_remaining", remaining, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_aborted", aborted, 0);
    check_eq("rst_ready_en", cmd_ready, 1);
    eec_en = 1'b0;
    #1;
    check_eq("rst_ready_dis", cmd_ready, 0);
    eec_en = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_cmd(15'h0005, 20);
    run_cmd(15'h7FFC, 20);
    run_cmd(15'h0000, 20);
    run_cmd(15'h7FFF, 20);
    run_cmd(15'd1000, 6);

    // abort in the third low clock of pulse 4
    tick_period = 20;
    clear_mon();
    send_cmd(15'd10, sat);
    void'(exp_q.pop_front());
    wait_p(4);
    @(posedge clk);
    @(posedge clk);
    #1;
    eec_en = 1'b0; trunc_ok = 1'b1;
    sample();
    check_eq("abort_still_low", p_pch, 0);
    cmd_valid = 1'b1;
    sample();
    check_eq("abort_line_high", p_pch, 1);
    check_eq("abort_strobe", aborted, 1);
    check_eq("abort_remaining", remaining, 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_ready", cmd_ready, 0);
    sample();
    check_eq("abort_strobe_1clk", aborted, 0);
    check_eq("disabled_ignores_valid", busy, 0);
    check_eq("abort_count", ab_cnt, 1);
    check_eq("abort_no_done", done_cnt, 0);
    check_eq("abort_pulses", p_cnt, 4);
    cmd_valid = 1'b0; eec_en = 1'b1;
    sample();
    trunc_ok = 1'b0;

    // fast ticks, then reset in the middle of pulse 3
    tick_period = 2;
    clear_mon();
    send_cmd(15'd20, sat);
    void'(exp_q.pop_front());
    wait_p(3);
    @(posedge clk);
    #1;
    rst = 1'b1; trunc_ok = 1'b1;
    sample();
    check_eq("rstmid_still_low", p_pch, 0);
    sample();
    check_eq("rstmid_line_high", p_pch, 1);
    check_eq("rstmid_remaining", remaining, 0);
    check_eq("rstmid_busy", busy, 0);
    check_eq("rstmid_done", done, 0);
    check_eq("rstmid_aborted", aborted, 0);
    check_eq("rstmid_ready", cmd_ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sample();
    trunc_ok = 1'b0;

    // randomized commands
    for (int k = 0; k < 12; k++) begin
      big    = ($urandom_range(0, 7) == 0);
      mag    = big ? int'($urandom_range(385, 16383)) : int'($urandom_range(0, 25));
      period = big ? int'($urandom_range(1, 6)) : int'($urandom_range(1, 25));
      c[13:0] = 14'(mag);
      c[14]   = 1'($urandom_range(0, 1));
      if (c[14]) c[13:0] = ~c[13:0];
      run_cmd(c, period);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
